// File: rtl/regfile_rob_pkg.sv
// Shared constants and types for the architectural register file with rename tags.
package regfile_rob_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROBEN_W   = 5;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREGS     = 32;

    typedef logic [ROBEN_W-1:0]   roben_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Tag value meaning "register holds the current value, no pending producer".
    localparam roben_t NO_ROBEN = '0;

endpackage

// File: rtl/regfile_rob_tag_table.sv
// Per-register rename tags: decode writes, commit match/clear, three combinational reads.
module regfile_rob_tag_table
    import regfile_rob_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     dec_wen,
    input  roben_t   dec_roben,
    input  reg_idx_t dec_idx,
    input  logic     cmt_wen,
    input  roben_t   cmt_roben,
    input  reg_idx_t cmt_idx,
    input  reg_idx_t rd_idx1,
    input  reg_idx_t rd_idx2,
    input  reg_idx_t rd_idx3,
    output roben_t   rd_tag1,
    output roben_t   rd_tag2,
    output roben_t   rd_tag3,
    output logic     cmt_match
);

    roben_t tag_q [NREGS];
    roben_t tag_d [NREGS];

    assign cmt_match = cmt_wen && (cmt_idx != '0) && (tag_q[cmt_idx] == cmt_roben);

    // Decode is applied after the commit clear so the younger rename wins.
    always_comb begin
        tag_d = tag_q;
        if (cmt_match) begin
            tag_d[cmt_idx] = NO_ROBEN;
        end
        if (dec_wen && (dec_idx != '0)) begin
            tag_d[dec_idx] = dec_roben;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                tag_q[i] <= NO_ROBEN;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign rd_tag1 = (rd_idx1 == '0) ? NO_ROBEN : tag_q[rd_idx1];
    assign rd_tag2 = (rd_idx2 == '0) ? NO_ROBEN : tag_q[rd_idx2];
    assign rd_tag3 = (rd_idx3 == '0) ? NO_ROBEN : tag_q[rd_idx3];

endmodule

// File: rtl/regfile_rob.sv
// Architectural register file with rename tags; commit data is written only when its ROB tag matches.
module regfile_rob
    import regfile_rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WP1_Wen,
    input  logic [ROBEN_W-1:0]   WP1_ROBEN,
    input  logic [REG_IDX_W-1:0] WP1_DRindex,
    input  logic [DATA_W-1:0]    WP1_Data,
    input  logic                 Decoded_WP1_Wen,
    input  logic [ROBEN_W-1:0]   Decoded_WP1_ROBEN,
    input  logic [REG_IDX_W-1:0] Decoded_WP1_DRindex,
    input  logic [REG_IDX_W-1:0] RP1_index1,
    input  logic [REG_IDX_W-1:0] RP1_index2,
    output logic [DATA_W-1:0]    RP1_Reg1,
    output logic [DATA_W-1:0]    RP1_Reg2,
    output logic [ROBEN_W-1:0]   RP1_Reg1_ROBEN,
    output logic [ROBEN_W-1:0]   RP1_Reg2_ROBEN,
    input  logic [REG_IDX_W-1:0] input_WP1_DRindex_test,
    output logic [ROBEN_W-1:0]   output_ROBEN_test
);

    logic              cmt_match;
    logic [DATA_W-1:0] data_q [NREGS];
    logic [DATA_W-1:0] data_d [NREGS];

    regfile_rob_tag_table u_tag_table (
        .clk       (clk),
        .rst       (rst),
        .dec_wen   (Decoded_WP1_Wen),
        .dec_roben (Decoded_WP1_ROBEN),
        .dec_idx   (Decoded_WP1_DRindex),
        .cmt_wen   (WP1_Wen),
        .cmt_roben (WP1_ROBEN),
        .cmt_idx   (WP1_DRindex),
        .rd_idx1   (RP1_index1),
        .rd_idx2   (RP1_index2),
        .rd_idx3   (input_WP1_DRindex_test),
        .rd_tag1   (RP1_Reg1_ROBEN),
        .rd_tag2   (RP1_Reg2_ROBEN),
        .rd_tag3   (output_ROBEN_test),
        .cmt_match (cmt_match)
    );

    always_comb begin
        data_d = data_q;
        if (cmt_match) begin
            data_d[WP1_DRindex] = WP1_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end

    assign RP1_Reg1 = (RP1_index1 == '0) ? '0 : data_q[RP1_index1];
    assign RP1_Reg2 = (RP1_index2 == '0) ? '0 : data_q[RP1_index2];

endmodule

// File: tb/tb_regfile_rob.sv
// Directed scoreboard bench: stimulus queues expected read results, a negedge monitor compares.
module tb_regfile_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        WP1_Wen;
    logic [4:0]  WP1_ROBEN;
    logic [4:0]  WP1_DRindex;
    logic [31:0] WP1_Data;
    logic        Decoded_WP1_Wen;
    logic [4:0]  Decoded_WP1_ROBEN;
    logic [4:0]  Decoded_WP1_DRindex;
    logic [4:0]  RP1_index1;
    logic [4:0]  RP1_index2;
    logic [31:0] RP1_Reg1;
    logic [31:0] RP1_Reg2;
    logic [4:0]  RP1_Reg1_ROBEN;
    logic [4:0]  RP1_Reg2_ROBEN;
    logic [4:0]  input_WP1_DRindex_test;
    logic [4:0]  output_ROBEN_test;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic [4:0]  td;
    } exp_t;

    exp_t exp_q [$];
    logic chk_valid = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    regfile_rob dut (
        .clk                    (clk),
        .rst                    (rst),
        .WP1_Wen                (WP1_Wen),
        .WP1_ROBEN              (WP1_ROBEN),
        .WP1_DRindex            (WP1_DRindex),
        .WP1_Data               (WP1_Data),
        .Decoded_WP1_Wen        (Decoded_WP1_Wen),
        .Decoded_WP1_ROBEN      (Decoded_WP1_ROBEN),
        .Decoded_WP1_DRindex    (Decoded_WP1_DRindex),
        .RP1_index1             (RP1_index1),
        .RP1_index2             (RP1_index2),
        .RP1_Reg1               (RP1_Reg1),
        .RP1_Reg2               (RP1_Reg2),
        .RP1_Reg1_ROBEN         (RP1_Reg1_ROBEN),
        .RP1_Reg2_ROBEN         (RP1_Reg2_ROBEN),
        .input_WP1_DRindex_test (input_WP1_DRindex_test),
        .output_ROBEN_test      (output_ROBEN_test)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per negedge on which a check is presented.
    always @(negedge clk) begin
        if (chk_valid) begin
            exp_t e;
            logic bad;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: check presented with no expected entry");
            end else begin
                e   = exp_q.pop_front();
                bad = 1'b0;
                if (RP1_Reg1 !== e.r1) begin
                    bad = 1'b1;
                    $display("FAIL %s reg1: got %0d expected %0d", e.name, RP1_Reg1, e.r1);
                end
                if (RP1_Reg2 !== e.r2) begin
                    bad = 1'b1;
                    $display("FAIL %s reg2: got %0d expected %0d", e.name, RP1_Reg2, e.r2);
                end
                if (RP1_Reg1_ROBEN !== e.t1) begin
                    bad = 1'b1;
                    $display("FAIL %s tag1: got %0d expected %0d", e.name, RP1_Reg1_ROBEN, e.t1);
                end
                if (RP1_Reg2_ROBEN !== e.t2) begin
                    bad = 1'b1;
                    $display("FAIL %s tag2: got %0d expected %0d", e.name, RP1_Reg2_ROBEN, e.t2);
                end
                if (output_ROBEN_test !== e.td) begin
                    bad = 1'b1;
                    $display("FAIL %s dbg_tag: got %0d expected %0d", e.name, output_ROBEN_test, e.td);
                end
                if (bad) n_bad++;
            end
        end
    end

    task automatic check(input string name, input logic [4:0] i1, input logic [4:0] i2,
                         input logic [4:0] id, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] t1, input logic [4:0] t2, input logic [4:0] td);
        exp_t e;
        e.name = name; e.r1 = r1; e.r2 = r2; e.t1 = t1; e.t2 = t2; e.td = td;
        RP1_index1 = i1;
        RP1_index2 = i2;
        input_WP1_DRindex_test = id;
        exp_q.push_back(e);
        chk_valid = 1'b1;
        @(negedge clk);
        #1 chk_valid = 1'b0;
    endtask

    task automatic drive(input logic cw, input logic [4:0] cdr, input logic [4:0] crob,
                         input logic [31:0] cdata, input logic dw, input logic [4:0] ddr,
                         input logic [4:0] drob);
        WP1_Wen = cw; WP1_DRindex = cdr; WP1_ROBEN = crob; WP1_Data = cdata;
        Decoded_WP1_Wen = dw; Decoded_WP1_DRindex = ddr; Decoded_WP1_ROBEN = drob;
        @(posedge clk);
        #1;
        WP1_Wen = 1'b0;
        Decoded_WP1_Wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        WP1_Wen = 1'b0; WP1_ROBEN = '0; WP1_DRindex = '0; WP1_Data = '0;
        Decoded_WP1_Wen = 1'b0; Decoded_WP1_ROBEN = '0; Decoded_WP1_DRindex = '0;
        RP1_index1 = '0; RP1_index2 = '0; input_WP1_DRindex_test = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            check("reset", 5'(i), 5'(9 - i), 5'(i), 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        end

        // Commit against old tag 0 misses; decode renames r1 to ROB 2.
        drive(1'b1, 5'd1, 5'd2, 32'd123, 1'b1, 5'd1, 5'd2);
        check("same_edge_rename", 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 5'd2, 5'd2, 5'd2);

        // Commit now matches; decode writes tag 0 on the same register.
        drive(1'b1, 5'd1, 5'd2, 32'd123, 1'b1, 5'd1, 5'd0);
        check("commit_match", 5'd1, 5'd2, 5'd1, 32'd123, 32'd0, 5'd0, 5'd0, 5'd0);
        check("others_unchanged", 5'd7, 5'd31, 5'd2, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7);
        check("rename_r5", 5'd5, 5'd1, 5'd5, 32'd0, 32'd123, 5'd7, 5'd0, 5'd7);
        drive(1'b1, 5'd5, 5'd3, 32'd9, 1'b0, 5'd0, 5'd0);
        check("commit_mismatch", 5'd5, 5'd5, 5'd5, 32'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        drive(1'b1, 5'd5, 5'd7, 32'd9, 1'b0, 5'd0, 5'd0);
        check("commit_r5", 5'd5, 5'd1, 5'd5, 32'd9, 32'd123, 5'd0, 5'd0, 5'd0);

        // Register 0: both writes ignored even though ROBEN 0 equals tag 0.
        drive(1'b1, 5'd0, 5'd0, 32'd55, 1'b1, 5'd0, 5'd4);
        check("reg0_hardwired", 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // Commit to a register whose tag was never written.
        drive(1'b1, 5'd4, 5'd3, 32'd44, 1'b0, 5'd0, 5'd0);
        check("unrenamed_mismatch", 5'd4, 5'd0, 5'd4, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // ROBEN 0 commit against tag 0 writes data; decode to another register is independent.
        drive(1'b1, 5'd8, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd10, 5'd11);
        check("roben0_write", 5'd8, 5'd10, 5'd10, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd11, 5'd11);

        drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd6);
        check("rename_r3", 5'd3, 5'd31, 5'd3, 32'd0, 32'd0, 5'd6, 5'd0, 5'd6);
        drive(1'b1, 5'd3, 5'd6, 32'd77, 1'b1, 5'd3, 5'd9);
        check("decode_wins", 5'd3, 5'd5, 5'd3, 32'd77, 32'd9, 5'd9, 5'd0, 5'd9);
        check("max_tag_slot", 5'd31, 5'd8, 5'd31, 32'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);

        // Reset overrides both write ports.
        rst = 1'b1;
        drive(1'b1, 5'd3, 5'd9, 32'd1, 1'b1, 5'd12, 5'd13);
        rst = 1'b0;
        check("rst_r3_r1", 5'd3, 5'd1, 5'd3, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        check("rst_r5_r8", 5'd5, 5'd8, 5'd12, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        check("rst_r10_r12", 5'd10, 5'd12, 5'd10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
